// File: rtl/data_if_arbiter.sv
// data_if_arbiter: round-robin arbiter that grants one requester at a time
// onto a shared beat datapath. A grant lasts until a beat carrying out_last is
// accepted, where out_last comes from the requester or from the MAX_BURST cap.
// After each grant the block spends one DONE cycle (done pulse, no grant)
// before it can arbitrate again.
`timescale 1ns/1ps
module data_if_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [2:0]                 out_id,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       done
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = IDW + 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   gnt_reg, gnt_next;
  logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [3:0]       count_reg, count_next;
  // Low for the first edge after reset so no grant can land on that edge.
  logic             armed_reg;

  logic [NUM_REQ-1:0] rot_valid;
  logic [PW-1:0]      pick_sum;
  logic [IDW-1:0]     pick_idx;
  logic               pick_found;

  logic [WIDTH-1:0] data_arr [NUM_REQ];

  // Split the flat data bus into one word per requester for the output mux.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: rotate the valid vector so bit 0 is rr_ptr, take the
  // lowest set bit and map it back to an absolute requester index.
  always_comb begin
    rot_valid  = NUM_REQ'({req_valid, req_valid} >> rr_ptr_reg);
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        pick_found = 1'b1;
        pick_sum   = PW'(rr_ptr_reg) + PW'(k);
      end
    end
    if (pick_sum >= PW'(NUM_REQ)) begin
      pick_sum = pick_sum - PW'(NUM_REQ);
    end
    pick_idx = pick_sum[IDW-1:0];
  end

  // State register; reset abandons any burst in flight without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      rr_ptr_reg <= '0;
      count_reg  <= '0;
      armed_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      rr_ptr_reg <= rr_ptr_next;
      count_reg  <= count_next;
      armed_reg  <= 1'b1;
    end
  end

  // Next-state logic and all outputs; the datapath is a pure mux of the
  // granted requester, so a stall simply holds everything in place.
  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    rr_ptr_next = rr_ptr_reg;
    count_next  = count_reg;
    req_ready   = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    out_id      = '0;
    grant       = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed_reg && enable && pick_found) begin
          state_next = XFER;
          gnt_next   = pick_idx;
          count_next = '0;
        end
      end
      XFER: begin
        busy               = 1'b1;
        grant[gnt_reg]     = 1'b1;
        out_id             = 3'(gnt_reg);
        out_valid          = req_valid[gnt_reg];
        out_data           = data_arr[gnt_reg];
        req_ready[gnt_reg] = out_ready;
        out_last           = req_last[gnt_reg] || (count_reg == 4'(MAX_BURST - 1));
        if (out_valid && out_ready) begin
          count_next = count_reg + 4'd1;
          if (out_last) begin
            state_next  = DONE;
            rr_ptr_next = (gnt_reg == IDW'(NUM_REQ - 1)) ? '0 : gnt_reg + IDW'(1);
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_if_arbiter.sv
// tb_data_if_arbiter: queue-level reference model feeds a scoreboard of
// expected beats; a driver process plays per-requester beat queues into the
// DUT and a monitor process checks every accepted beat and cycle invariants.
`timescale 1ns/1ps
module tb_data_if_arbiter;
  localparam int W  = 32;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            enable = 1'b0;
  logic            out_ready = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR*W-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [2:0]      out_id;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            done;

  data_if_arbiter #(.WIDTH(W), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_id(out_id), .out_ready(out_ready),
    .grant(grant), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [2:0] id; logic [W-1:0] data; logic last; } exp_t;

  beat_t drv_q [NR][$];   // what each requester still has to send
  beat_t mq    [NR][$];   // reference model's copy of the same traffic
  exp_t  exp_q [$];       // scoreboard of expected accepted beats

  int checks = 0, failures = 0;
  int done_cnt = 0, beat_cnt = 0, done_base = 0, phase_grants = 0;
  int m_ptr = 0, dead_stalls = 0;
  logic [NR-1:0] acc = '0;
  bit bubble_en = 0, ready_rand = 0, dead_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mq_empty();
    for (int i = 0; i < NR; i++) if (mq[i].size() > 0) return 0;
    return 1;
  endfunction

  function automatic bit drv_empty();
    for (int i = 0; i < NR; i++) if (drv_q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic push_beat(input int r, input logic [W-1:0] d, input logic l);
    beat_t b;
    b = '{data: d, last: l};
    drv_q[r].push_back(b);
    mq[r].push_back(b);
  endtask

  // Reference model: repeatedly grant the first non-empty requester from the
  // pointer; a grant ends on a last-flagged beat or on its MB-th beat.
  task automatic start_phase();
    int g, beats;
    bit fin;
    beat_t b;
    done_base    = done_cnt;
    phase_grants = 0;
    while (!mq_empty()) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      beats = 0;
      fin   = 0;
      while (!fin && mq[g].size() > 0) begin
        b   = mq[g].pop_front();
        fin = b.last || (beats == MB - 1);
        exp_q.push_back('{id: 3'(g), data: b.data, last: fin});
        beats++;
      end
      m_ptr = (g + 1) % NR;
      phase_grants++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && drv_empty() && !busy && !done) && n < 3000) begin
      @(negedge clk); #4;
      n++;
    end
    chk({name, "_drained"}, 64'(n < 3000), 64'd1);
    chk({name, "_done_count"}, 64'(done_cnt - done_base), 64'(phase_grants));
    $display("phase %s grants=%0d cycles=%0d", name, phase_grants, n);
  endtask

  task automatic wait_beats(input string name, input int target);
    int n = 0;
    while ((beat_cnt < target || !busy) && n < 500) begin
      @(negedge clk); #4;
      n++;
    end
    chk({name, "_reached"}, 64'(n < 500), 64'd1);
  endtask

  // Driver: retire beats accepted on the previous edge, present queue heads,
  // then choose out_ready and note which handshakes the next edge completes.
  always begin
    beat_t hb;
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      if (acc[i] && drv_q[i].size() > 0) drv_q[i].delete(0);
    acc = '0;
    for (int i = 0; i < NR; i++) begin
      if (drv_q[i].size() > 0) begin
        hb = drv_q[i][0];
        req_valid[i]         = !(bubble_en && grant[i] && ($urandom_range(0, 4) == 0));
        req_data[i*W +: W]   = hb.data;
        req_last[i]          = hb.last;
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*W +: W]   = '0;
      end
    end
    #1;
    if (dead_en && out_valid && out_data == 32'hDEADBEEF && dead_stalls < 3) begin
      out_ready = 1'b0;
      dead_stalls++;
    end else begin
      out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    acc = req_valid & req_ready;
  end

  // Monitor: cycle invariants plus scoreboard comparison of accepted beats.
  logic          prev_last_acc = 0, prev_stall = 0;
  logic [2:0]    prev_id = '0;
  logic [W-1:0]  prev_data = '0;
  logic [NR-1:0] exp_grant;
  always begin
    exp_t e;
    @(negedge clk); #3;
    if (!reset_n) begin
      prev_last_acc = 0;
      prev_stall    = 0;
    end else begin
      exp_grant = busy ? (NR'(1) << out_id) : '0;
      chk("grant_vs_id", 64'(grant), 64'(exp_grant));
      if (!busy) begin
        chk("idle_quiet", 64'({out_valid, out_last, out_id, req_ready}), 64'd0);
      end else begin
        chk("ready_route", 64'(req_ready), 64'(out_ready ? (NR'(1) << out_id) : NR'(0)));
        chk("valid_route", 64'(out_valid), 64'(req_valid[out_id]));
        chk("data_route", 64'(out_data), 64'(req_data[out_id*W +: W]));
      end
      chk("done_pulse", 64'(done), 64'(prev_last_acc));
      if (prev_stall) chk("stall_hold", 64'({busy, out_id, out_data}), 64'({1'b1, prev_id, prev_data}));
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        beat_cnt++;
        $display("beat id=%0d data=%08h last=%0b", out_id, out_data, out_last);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'({out_id, out_data, out_last}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'({out_id, out_data, out_last}), 64'({e.id, e.data, e.last}));
        end
      end
      prev_last_acc = out_valid && out_ready && out_last;
      prev_stall    = out_valid && !out_ready;
      prev_id       = out_id;
      prev_data     = out_data;
    end
  end

  initial begin
    int db, nb, len;
    // Reset state.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_out", 64'({out_valid, out_last, out_id}), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    // Single burst from requester 2, pending before reset is released.
    enable = 1'b1;
    push_beat(2, 32'hA5A5A5A5, 1'b0);
    push_beat(2, 32'h5A5A5A5A, 1'b1);
    start_phase();
    repeat (2) @(negedge clk);
    #4 reset_n = 1'b1;
    @(negedge clk); #4;
    chk("first_grant_delay", 64'({busy, grant}), 64'd0);
    drain("single_burst");
    chk("idle_after_burst", 64'({busy, grant}), 64'd0);

    // Burst cap: six beats, no last until the sixth.
    for (int j = 0; j < 6; j++) push_beat(1, 32'h10000000 + 32'(j), j == 5);
    start_phase();
    drain("burst_cap");

    // Backpressure on the DEADBEEF beat.
    dead_en = 1; dead_stalls = 0;
    push_beat(0, 32'h11111111, 1'b0);
    push_beat(0, 32'hDEADBEEF, 1'b0);
    push_beat(0, 32'h22222222, 1'b1);
    start_phase();
    drain("backpressure");
    chk("deadbeef_stalls", 64'(dead_stalls), 64'd3);
    dead_en = 0;

    // Enable drop mid-burst; requester 3 must wait until enable returns.
    for (int j = 0; j < 4; j++) push_beat(1, 32'hC0000000 + 32'(j), j == 3);
    push_beat(3, 32'hFFFFFFFF, 1'b1);
    start_phase();
    wait_beats("enable_drop_beat2", beat_cnt + 2);
    enable = 1'b0;
    begin
      int n = 0;
      while (done_cnt < done_base + 1 && n < 200) begin
        @(negedge clk); #4;
        n++;
      end
      chk("enable_drop_done", 64'(done_cnt - done_base), 64'd1);
    end
    repeat (8) begin
      @(negedge clk); #4;
      chk("no_grant_disabled", 64'({busy, grant}), 64'd0);
    end
    enable = 1'b1;
    drain("enable_drop");

    // Reset in the middle of a burst.
    push_beat(0, 32'h0BADF00D, 1'b1);
    for (int j = 0; j < 5; j++) push_beat(2, $urandom, j == 4);
    start_phase();
    wait_beats("midrst_reach", beat_cnt + 3);
    reset_n = 1'b0;
    #0.5;
    chk("midrst_grant", 64'({busy, done, grant}), 64'd0);
    chk("midrst_out", 64'({out_valid, out_last, out_id}), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < NR; i++) begin
      drv_q[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    acc   = '0;
    m_ptr = 0;
    db    = done_cnt;
    repeat (3) @(negedge clk);
    #4 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("midrst_no_done", 64'(done_cnt), 64'(db));

    // Round robin from requester 0 after reset: order 0,1,2,3,0.
    for (int i = 0; i < NR; i++) push_beat(i, 32'hA0000000 + 32'(i), 1'b1);
    push_beat(0, 32'hA0000010, 1'b1);
    start_phase();
    drain("round_robin");

    // Randomized traffic with bubbles and random backpressure.
    bubble_en = 1; ready_rand = 1;
    for (int p = 0; p < 20; p++) begin
      for (int r = 0; r < NR; r++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) push_beat(r, $urandom, j == len - 1);
        end
      end
      start_phase();
      drain("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
